// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//
// Hazard and sequencing controller for a 5-stage RV32I pipeline
// (IF/ID/EX/MEM/WB).
//
// The controller keeps a shadow copy of the register-usage information for
// every in-flight instruction. From that shadow copy it produces:
//   - EX operand forwarding selects (fwd_a / fwd_b),
//   - load-use stalls,
//   - taken-branch flushes,
//   - whole-pipeline freezes while data memory is busy.
// It also keeps two saturating event counters for performance debug.
//
// Forwarding select encoding (forwarding_type):
//   2'b00 NONE    operand comes from the register file
//   2'b10 EX_MEM  operand comes from the instruction now in MEM
//   2'b01 MEM_WB  operand comes from the instruction now in WB
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   id_*                decoded register usage of the instruction in ID
//   ex_branch_taken     EX resolved a taken branch or jump
//   mem_busy            data memory not ready; the whole pipe must hold
//   stall_if, stall_id  hold the PC and the IF/ID register
//   flush_id            clear IF/ID to a NOP
//   bubble_ex           load a NOP into ID/EX
//   freeze              hold every pipeline register
//   fwd_a, fwd_b        forwarding selects for EX operands A and B
//   load_use_cnt        number of load-use stall cycles (saturating)
//   flush_cnt           number of taken-branch flushes (saturating)
// -----------------------------------------------------------------------------
module hazard_controller #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_uses_rs1,
    input  logic                      id_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_reg_write,
    input  logic                      id_is_load,
    input  logic                      ex_branch_taken,
    input  logic                      mem_busy,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      flush_id,
    output logic                      bubble_ex,
    output logic                      freeze,
    output logic [1:0]                fwd_a,
    output logic [1:0]                fwd_b,
    output logic [CNT_WIDTH-1:0]      load_use_cnt,
    output logic [CNT_WIDTH-1:0]      flush_cnt
);

    localparam logic [1:0] FWD_NONE   = 2'b00;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } state_t;

    // Shadow pipeline: EX, MEM and WB register-usage info
    logic                      ex_valid_q, ex_use1_q, ex_use2_q, ex_we_q, ex_load_q;
    logic [REG_ADDR_WIDTH-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
    logic                      mem_valid_q, mem_we_q;
    logic [REG_ADDR_WIDTH-1:0] mem_rd_q;
    logic                      wb_valid_q, wb_we_q;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_q;

    state_t                    state_q, state_d;
    logic [CNT_WIDTH-1:0]      load_use_cnt_q, flush_cnt_q;

    logic                      lu;
    logic                      lu_inc, flush_inc;
    logic                      mem_fwd_ok, wb_fwd_ok;

    // Load-use: the load in EX produces a register the ID instruction reads
    assign lu = id_valid && ex_valid_q && ex_load_q && (ex_rd_q != '0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd_q)) ||
                 (id_uses_rs2 && (id_rs2 == ex_rd_q)));

    // A stage may forward only if it writes a register other than x0
    assign mem_fwd_ok = mem_valid_q && mem_we_q && (mem_rd_q != '0);
    assign wb_fwd_ok  = wb_valid_q  && wb_we_q  && (wb_rd_q  != '0);

    // Forwarding: the younger result (MEM) wins over the older one (WB)
    always_comb begin
        fwd_a = FWD_NONE;
        if (ex_use1_q && mem_fwd_ok && (mem_rd_q == ex_rs1_q)) begin
            fwd_a = FWD_EX_MEM;
        end else if (ex_use1_q && wb_fwd_ok && (wb_rd_q == ex_rs1_q)) begin
            fwd_a = FWD_MEM_WB;
        end
    end

    always_comb begin
        fwd_b = FWD_NONE;
        if (ex_use2_q && mem_fwd_ok && (mem_rd_q == ex_rs2_q)) begin
            fwd_b = FWD_EX_MEM;
        end else if (ex_use2_q && wb_fwd_ok && (wb_rd_q == ex_rs2_q)) begin
            fwd_b = FWD_MEM_WB;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (mem_busy)  state_d = ST_FROZEN;
            ST_FROZEN: if (!mem_busy) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    // FSM: outputs. Control outputs are forced low while reset is held so
    // the pipeline sees a quiet controller immediately.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;
        freeze    = 1'b0;
        lu_inc    = 1'b0;
        flush_inc = 1'b0;
        if (reset) begin
            freeze = 1'b0;
        end else if (mem_busy) begin
            // EX/ID are held, so any branch or load-use is handled later
            freeze = 1'b1;
        end else if (ex_branch_taken) begin
            // Flush wins over a simultaneous load-use; PC must redirect
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
            flush_inc = 1'b1;
        end else if (lu) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
            lu_inc    = 1'b1;
        end
    end

    // Shadow pipeline advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q  <= 1'b0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_use1_q   <= 1'b0;
            ex_use2_q   <= 1'b0;
            ex_rd_q     <= '0;
            ex_we_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= '0;
            mem_we_q    <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_we_q     <= 1'b0;
        end else if (!freeze) begin
            wb_valid_q  <= mem_valid_q;
            wb_rd_q     <= mem_rd_q;
            wb_we_q     <= mem_we_q;
            mem_valid_q <= ex_valid_q;
            mem_rd_q    <= ex_rd_q;
            mem_we_q    <= ex_we_q;
            if (bubble_ex || !id_valid) begin
                ex_valid_q <= 1'b0;
                ex_rs1_q   <= '0;
                ex_rs2_q   <= '0;
                ex_use1_q  <= 1'b0;
                ex_use2_q  <= 1'b0;
                ex_rd_q    <= '0;
                ex_we_q    <= 1'b0;
                ex_load_q  <= 1'b0;
            end else begin
                ex_valid_q <= 1'b1;
                ex_rs1_q   <= id_rs1;
                ex_rs2_q   <= id_rs2;
                ex_use1_q  <= id_uses_rs1;
                ex_use2_q  <= id_uses_rs2;
                ex_rd_q    <= id_rd;
                ex_we_q    <= id_reg_write;
                ex_load_q  <= id_is_load;
            end
        end
    end

    // Saturating event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_use_cnt_q <= '0;
            flush_cnt_q    <= '0;
        end else begin
            if (lu_inc && (load_use_cnt_q != CNT_MAX)) begin
                load_use_cnt_q <= load_use_cnt_q + CNT_ONE;
            end
            if (flush_inc && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
        end
    end

    assign load_use_cnt = load_use_cnt_q;
    assign flush_cnt    = flush_cnt_q;

    // A frozen cycle must never count an event
    a_no_count_frozen: assert property (
        @(posedge clk) disable iff (reset)
        (state_d == ST_FROZEN) |-> !(lu_inc || flush_inc)
    );

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

    localparam int N  = 0;   // NONE
    localparam int EM = 2;   // EX_MEM
    localparam int MW = 1;   // MEM_WB

    // Control word {stall_if, stall_id, flush_id, bubble_ex, freeze}
    localparam int C0  = 5'b00000;
    localparam int CLU = 5'b11010;
    localparam int CBR = 5'b00110;
    localparam int CFZ = 5'b00001;

    localparam int NVEC = 25;

    typedef struct {
        int v, rs1, rs2, u1, u2, rd, we, ld, br, busy;
        int ctl, fa, fb, lc, fc;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_is_load;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        ex_branch_taken, mem_busy;

    logic        stall_if, stall_id, flush_id, bubble_ex, freeze;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] load_use_cnt, flush_cnt;

    logic        s_stall_if, s_stall_id, s_flush_id, s_bubble_ex, s_freeze;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [1:0]  s_load_use_cnt, s_flush_cnt;

    logic [4:0]  ctl;
    assign ctl = {stall_if, stall_id, flush_id, bubble_ex, freeze};

    int n_checks = 0;
    int n_err    = 0;
    vec_t vecs[NVEC];

    hazard_controller #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
        .bubble_ex(bubble_ex), .freeze(freeze),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .load_use_cnt(load_use_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter instance for saturation
    hazard_controller #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .stall_if(s_stall_if), .stall_id(s_stall_id), .flush_id(s_flush_id),
        .bubble_ex(s_bubble_ex), .freeze(s_freeze),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .load_use_cnt(s_load_use_cnt), .flush_cnt(s_flush_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(int v, int rs1, int rs2, int u1, int u2, int rd,
                                int we, int ld, int br, int busy,
                                int c, int fa, int fb, int lc, int fc);
        vec_t r;
        r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.rd = rd;
        r.we = we; r.ld = ld; r.br = br; r.busy = busy;
        r.ctl = c; r.fa = fa; r.fb = fb; r.lc = lc; r.fc = fc;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_id(input int v, input int rs1, input int rs2, input int u1,
                            input int u2, input int rd, input int we, input int ld);
        id_valid     = 1'(v);
        id_rs1       = 5'(rs1);
        id_rs2       = 5'(rs2);
        id_uses_rs1  = 1'(u1);
        id_uses_rs2  = 1'(u2);
        id_rd        = 5'(rd);
        id_reg_write = 1'(we);
        id_is_load   = 1'(ld);
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        ex_branch_taken = 1'b0;
        mem_busy        = 1'b0;

        // mk(v, rs1, rs2, u1, u2, rd, we, ld, br, busy, ctl, fa, fb, lc, fc)
        // ADD x5 then consumer rs1=x5: EX_MEM on operand A only
        vecs[0]  = mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, C0, N,  N,  0, 0);
        vecs[1]  = mk(1, 5, 3, 1, 1, 6, 1, 0, 0, 0, C0, N,  N,  0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C0, EM, N,  0, 0);
        // Two writers of x7, consumer reads x7 twice: younger wins
        vecs[3]  = mk(1, 0, 0, 1, 0, 7, 1, 0, 0, 0, C0, N,  N,  0, 0);
        vecs[4]  = mk(1, 0, 0, 1, 0, 7, 1, 0, 0, 0, C0, N,  N,  0, 0);
        vecs[5]  = mk(1, 7, 7, 1, 1, 8, 1, 0, 0, 0, C0, N,  N,  0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C0, EM, EM, 0, 0);
        // Same with rd = x0: never forwards
        vecs[7]  = mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, C0, N,  N,  0, 0);
        vecs[8]  = mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, C0, N,  N,  0, 0);
        vecs[9]  = mk(1, 0, 0, 1, 1, 9, 1, 0, 0, 0, C0, N,  N,  0, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C0, N,  N,  0, 0);
        // LW x3, ADD reading rs2=x3: one stall cycle, then MEM_WB on B
        vecs[11] = mk(1, 1, 0, 1, 0, 3, 1, 1, 0, 0, C0,  N, N,  0, 0);
        vecs[12] = mk(1, 2, 3, 1, 1, 4, 1, 0, 0, 0, CLU, N, N,  0, 0);
        vecs[13] = mk(1, 2, 3, 1, 1, 4, 1, 0, 0, 0, C0,  N, N,  1, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C0,  N, MW, 1, 0);
        // Taken branch on the same cycle as a load-use
        vecs[15] = mk(1, 1, 0, 1, 0, 3,  1, 1, 0, 0, C0,  N, N, 1, 0);
        vecs[16] = mk(1, 3, 0, 1, 0, 10, 1, 0, 1, 0, CBR, N, N, 1, 0);
        vecs[17] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, C0,  N, N, 1, 1);
        // Freeze for 3 cycles with EX_MEM active, branch ignored meanwhile
        vecs[18] = mk(1, 1,  2, 1, 1, 11, 1, 0, 0, 0, C0,  N,  N, 1, 1);
        vecs[19] = mk(1, 11, 1, 1, 1, 12, 1, 0, 0, 0, C0,  N,  N, 1, 1);
        vecs[20] = mk(1, 11, 0, 1, 0, 13, 1, 1, 1, 1, CFZ, EM, N, 1, 1);
        vecs[21] = mk(1, 11, 0, 1, 0, 13, 1, 1, 1, 1, CFZ, EM, N, 1, 1);
        vecs[22] = mk(1, 11, 0, 1, 0, 13, 1, 1, 1, 1, CFZ, EM, N, 1, 1);
        vecs[23] = mk(1, 11, 0, 1, 0, 13, 1, 1, 0, 0, C0,  EM, N, 1, 1);
        vecs[24] = mk(0, 0,  0, 0, 0, 0,  0, 0, 0, 0, C0,  MW, N, 1, 1);

        #1;
        check("reset ctl",   32'(ctl), 32'(C0));
        check("reset fwd_a", 32'(fwd_a), 32'(N));
        check("reset fwd_b", 32'(fwd_b), 32'(N));
        check("reset lu_cnt", 32'(load_use_cnt), 32'd0);
        check("reset fl_cnt", 32'(flush_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Table-driven vectors, one per cycle
        for (int i = 0; i < NVEC; i++) begin
            drive_id(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
                     vecs[i].rd, vecs[i].we, vecs[i].ld);
            ex_branch_taken = 1'(vecs[i].br);
            mem_busy        = 1'(vecs[i].busy);
            #2;
            check($sformatf("v%0d ctl", i),    32'(ctl),          32'(vecs[i].ctl));
            check($sformatf("v%0d fwd_a", i),  32'(fwd_a),        32'(vecs[i].fa));
            check($sformatf("v%0d fwd_b", i),  32'(fwd_b),        32'(vecs[i].fb));
            check($sformatf("v%0d lu_cnt", i), 32'(load_use_cnt), 32'(vecs[i].lc));
            check($sformatf("v%0d fl_cnt", i), 32'(flush_cnt),    32'(vecs[i].fc));
            @(posedge clk);
            #1;
        end

        // Async reset in the middle of a load-use stall
        drive_id(1, 1, 0, 1, 0, 3, 1, 1);
        ex_branch_taken = 1'b0;
        mem_busy        = 1'b0;
        @(posedge clk);
        #1;
        drive_id(1, 3, 0, 1, 0, 4, 1, 0);
        #2;
        check("pre-reset ctl", 32'(ctl), 32'(CLU));
        #1;
        reset           = 1'b1;
        mem_busy        = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        check("mid-stall reset ctl",    32'(ctl),           32'(C0));
        check("mid-stall reset fwd_a",  32'(fwd_a),         32'(N));
        check("mid-stall reset fwd_b",  32'(fwd_b),         32'(N));
        check("mid-stall reset lu_cnt", 32'(load_use_cnt),  32'd0);
        check("mid-stall reset fl_cnt", 32'(flush_cnt),     32'd0);
        check("mid-stall reset sat fl", 32'(s_flush_cnt),   32'd0);
        check("mid-stall reset sat lu", 32'(s_load_use_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset           = 1'b0;
        mem_busy        = 1'b0;
        ex_branch_taken = 1'b1;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);

        // Five flushes: the 2-bit counter stops at 3
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("flush %0d fl_cnt", k),  32'(flush_cnt),   32'(k));
            check($sformatf("flush %0d sat fl", k),  32'(s_flush_cnt), 32'((k > 3) ? 3 : k));
        end
        ex_branch_taken = 1'b0;
        @(posedge clk);
        #1;
        check("after flushes sat fl", 32'(s_flush_cnt), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline hazard and sequencing controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Keeps a shadow pipeline of the destination and source register info for each in-flight instruction.
- From that shadow state it generates the EX-stage operand forwarding selects (forwarding_type), load-use stalls, taken-branch flushes and data-memory freezes.
- Also counts stall and flush events in saturating counters for performance debug.

Parameters:
- REG_ADDR_WIDTH, 5, register index width.
- CNT_WIDTH, 16, width of the saturating event counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  REG_ADDR_WIDTH  ID source register 1.
- id_rs2  in  REG_ADDR_WIDTH  ID source register 2.
- id_uses_rs1  in  1  ID instruction reads rs1 (0 for U/J types).
- id_uses_rs2  in  1  ID instruction reads rs2 (R, S, B types only).
- id_rd  in  REG_ADDR_WIDTH  ID destination register.
- id_reg_write  in  1  ID instruction writes rd.
- id_is_load  in  1  ID opcode is LOAD.
- ex_branch_taken  in  1  EX resolved a taken branch or jump (JAL/JALR/BRANCH).
- mem_busy  in  1  data memory not ready; pipeline must freeze.
- stall_if  out  1  hold PC.
- stall_id  out  1  hold IF/ID register.
- flush_id  out  1  clear IF/ID to NOP.
- bubble_ex  out  1  load NOP into ID/EX.
- freeze  out  1  hold every pipeline register.
- fwd_a  out  2  forwarding_type select for the EX operand A.
- fwd_b  out  2  forwarding_type select for the EX operand B.
- load_use_cnt  out  CNT_WIDTH  load-use stall cycles.
- flush_cnt  out  CNT_WIDTH  taken-branch flushes.

Behaviour:
- Shadow registers:
  - EX: {valid, rs1, rs2, use1, use2, rd, we, load}.
  - MEM: {valid, rd, we}.
  - WB: {valid, rd, we}.
- Reset (async, active-high, at any time including mid-stall or mid-freeze):
  - All shadow valid and we bits are 0; counters are 0.
  - All outputs are 0; fwd_a/fwd_b = NONE.
- Advance, when freeze=0:
  - WB<=MEM.
  - MEM<=EX.
  - EX<=ID info, or a bubble (valid=0, we=0) when bubble_ex=1 or id_valid=0.
- Freeze, when freeze=1: all shadow registers hold.
- Forwarding is combinational from the shadow state; it applies to operand A and likewise to operand B:
  - EX_MEM if MEM.we && MEM.rd!=0 && MEM.rd==EX.rs1 && EX.use1.
  - Otherwise MEM_WB if the same test passes against WB.
  - Otherwise NONE.
  - EX_MEM has priority over MEM_WB.
  - Writes to x0 never forward.
- Load-use condition (lu):
  - EX.valid && EX.load && EX.rd!=0, and
  - either (id_uses_rs1 && id_rs1==EX.rd) or (id_uses_rs2 && id_rs2==EX.rd), and
  - id_valid.
- Output priority, highest first:
  1. mem_busy: freeze=1; all other control outputs 0; counters hold. A branch or load-use hazard is acted on after mem_busy drops, because EX/ID are held.
  2. ex_branch_taken: flush_id=1 and bubble_ex=1; stall_if=stall_id=0 so the PC redirects. The flush overrides a simultaneous lu, and lu is not counted.
  3. lu: stall_if=1, stall_id=1, bubble_ex=1. Lasts exactly one cycle, because the load moves to MEM afterwards.
  4. Otherwise all control outputs are 0.
- State machine (2 states):
  - RUN: the normal state.
  - FROZEN: entered when mem_busy=1; returns to RUN on the first cycle with mem_busy=0.
  - freeze = mem_busy, independent of state.
  - The state is used only to assert that no counter increments while FROZEN.
- Counters:
  - load_use_cnt increments by 1 on each cycle with case 3 active.
  - flush_cnt increments by 1 on each cycle with case 2 active.
  - Both saturate at all-ones and never wrap.

Test Plan:
- EX forwarding, MEM path:
  - Stimulus: ADD x5 into the pipe, then ADD using rs1=x5 on the next instruction; no mem_busy.
  - Required: on the cycle the consumer is in EX, fwd_a=EX_MEM and fwd_b=NONE.
- Priority and x0:
  - Stimulus: write x7 from two consecutive instructions, then a consumer with rs1=rs2=x7.
  - Required: fwd_a=fwd_b=EX_MEM.
  - Stimulus: repeat with rd=x0.
  - Required: NONE.
- Load-use:
  - Stimulus: LW x3, then ADD reading rs2=x3.
  - Required: stall_if=stall_id=bubble_ex=1 for exactly 1 cycle.
  - Required: next cycle the consumer is in EX with fwd_b=MEM_WB.
  - Required: load_use_cnt=1.
- Branch vs load-use:
  - Stimulus: ex_branch_taken=1 on the same cycle lu holds.
  - Required: flush_id=bubble_ex=1, stall_if=0, flush_cnt=1, load_use_cnt unchanged.
- Freeze:
  - Stimulus: mem_busy=1 for 3 cycles while a forward to EX_MEM is active.
  - Required: freeze=1 for 3 cycles, fwd_a stays EX_MEM, shadow unchanged, counters unchanged.
  - Required: normal advance on cycle 4.
- Reset and saturation:
  - Stimulus: assert reset asynchronously mid-stall.
  - Required: all outputs 0 and NONE immediately.
  - Stimulus: CNT_WIDTH=2 with 5 flushes.
  - Required: flush_cnt=3.
